// File: rtl/fetch_unit_pipelined.sv
// Instruction-fetch stage: owns the PC, issues one read per cycle to a 1-cycle-latency
// instruction memory, and presents fetched words in an IF/ID register backed by a skid entry.
module fetch_unit_pipelined #(
  parameter int          B        = 32,
  parameter int          W        = 32,
  parameter logic [B-1:0] RESET_PC = '0,
  parameter int          PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_en,
  input  logic [B-1:0] redirect_pc,
  input  logic         stall,
  output logic         imem_en,
  output logic [B-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  output logic         ifid_valid,
  output logic [W-1:0] ifid_instr,
  output logic [B-1:0] ifid_pc,
  output logic [B-1:0] ifid_pc_inc,
  output logic [B-1:0] pc_out
);

  localparam logic [B-1:0] STEP = B'(PC_STEP);

  logic [B-1:0] pc_reg,          pc_next;
  logic         rsp_pending_reg, rsp_pending_next;
  logic [B-1:0] rsp_pc_reg,      rsp_pc_next;
  logic         ifid_valid_reg,  ifid_valid_next;
  logic [W-1:0] ifid_instr_reg,  ifid_instr_next;
  logic [B-1:0] ifid_pc_reg,     ifid_pc_next;
  logic [B-1:0] ifid_pc_inc_reg, ifid_pc_inc_next;
  logic         skid_valid_reg,  skid_valid_next;
  logic [W-1:0] skid_instr_reg,  skid_instr_next;
  logic [B-1:0] skid_pc_reg,     skid_pc_next;

  logic issue;
  logic ifid_free;

  // Issue only when every word already in flight is guaranteed a slot.
  assign issue     = !redirect_en && !skid_valid_reg &&
                     !(ifid_valid_reg && stall && rsp_pending_reg);
  assign ifid_free = !ifid_valid_reg || !stall;

  always_comb begin
    pc_next          = pc_reg;
    rsp_pending_next = issue;
    rsp_pc_next      = rsp_pc_reg;
    ifid_valid_next  = ifid_valid_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_pc_next     = ifid_pc_reg;
    ifid_pc_inc_next = ifid_pc_inc_reg;
    skid_valid_next  = skid_valid_reg;
    skid_instr_next  = skid_instr_reg;
    skid_pc_next     = skid_pc_reg;

    if (redirect_en) begin
      pc_next = redirect_pc;
    end else if (issue) begin
      pc_next     = pc_reg + STEP;
      rsp_pc_next = pc_reg;
    end

    if (redirect_en) begin
      ifid_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (rsp_pending_reg) begin
      if (skid_valid_reg && ifid_free) begin
        ifid_valid_next  = 1'b1;
        ifid_instr_next  = skid_instr_reg;
        ifid_pc_next     = skid_pc_reg;
        ifid_pc_inc_next = skid_pc_reg + STEP;
        skid_valid_next  = 1'b1;
        skid_instr_next  = imem_rdata;
        skid_pc_next     = rsp_pc_reg;
      end else if (ifid_free) begin
        ifid_valid_next  = 1'b1;
        ifid_instr_next  = imem_rdata;
        ifid_pc_next     = rsp_pc_reg;
        ifid_pc_inc_next = rsp_pc_reg + STEP;
      end else begin
        skid_valid_next  = 1'b1;
        skid_instr_next  = imem_rdata;
        skid_pc_next     = rsp_pc_reg;
      end
    end else if (skid_valid_reg && ifid_free) begin
      ifid_valid_next  = 1'b1;
      ifid_instr_next  = skid_instr_reg;
      ifid_pc_next     = skid_pc_reg;
      ifid_pc_inc_next = skid_pc_reg + STEP;
      skid_valid_next  = 1'b0;
    end else if (ifid_valid_reg && !stall) begin
      ifid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      rsp_pending_reg <= 1'b0;
      rsp_pc_reg      <= '0;
      ifid_valid_reg  <= 1'b0;
      ifid_instr_reg  <= '0;
      ifid_pc_reg     <= '0;
      ifid_pc_inc_reg <= '0;
      skid_valid_reg  <= 1'b0;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      rsp_pending_reg <= rsp_pending_next;
      rsp_pc_reg      <= rsp_pc_next;
      ifid_valid_reg  <= ifid_valid_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_pc_reg     <= ifid_pc_next;
      ifid_pc_inc_reg <= ifid_pc_inc_next;
      skid_valid_reg  <= skid_valid_next;
      skid_instr_reg  <= skid_instr_next;
      skid_pc_reg     <= skid_pc_next;
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = pc_reg;
  assign pc_out      = pc_reg;
  assign ifid_valid  = ifid_valid_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_pc     = ifid_pc_reg;
  assign ifid_pc_inc = ifid_pc_inc_reg;

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Bench for fetch_unit_pipelined: directed cycle-exact scenarios plus a randomized run
// checked against an in-order PC stream model.
module tb_fetch_unit_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_inc;
  logic [31:0] pc_out;

  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic        stall8;
  logic        imem_en8;
  logic [7:0]  imem_addr8;
  logic [7:0]  imem_rdata8;
  logic        ifid_valid8;
  logic [7:0]  ifid_instr8;
  logic [7:0]  ifid_pc8;
  logic [7:0]  ifid_pc_inc8;
  logic [7:0]  pc_out8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit_pipelined #(.B(32), .W(32)) dut (
    .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_inc(ifid_pc_inc), .pc_out(pc_out)
  );

  fetch_unit_pipelined #(.B(8), .W(8)) dut8 (
    .clk(clk), .reset(reset), .redirect_en(redirect8), .redirect_pc(redirect_pc8),
    .stall(stall8), .imem_en(imem_en8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .ifid_valid(ifid_valid8), .ifid_instr(ifid_instr8), .ifid_pc(ifid_pc8),
    .ifid_pc_inc(ifid_pc_inc8), .pc_out(pc_out8)
  );

  // Synchronous memories: word content is a fixed function of its address.
  always @(posedge clk) if (imem_en)  imem_rdata  <= imem_addr ^ 32'hA5A5A5A5;
  always @(posedge clk) if (imem_en8) imem_rdata8 <= imem_addr8 ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic st);
    @(negedge clk);
    redirect_en = rd;
    redirect_pc = rpc;
    stall       = st;
    #1;
  endtask

  // Leaves the bench at cycle 0 (first cycle after release), inputs idle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;
    redirect8 = 1'b0; redirect_pc8 = '0; stall8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd1);
    chk({tag, "_pc"},    ifid_pc,     pc);
    chk({tag, "_inc"},   ifid_pc_inc, pc + 32'd4);
    chk({tag, "_instr"}, ifid_instr,  pc ^ 32'hA5A5A5A5);
  endtask

  logic [31:0] exp_pc, rpc, prev_pc, prev_instr;
  logic        rd, st, prev_hold;
  int          consumed;

  initial begin
    // Reset state and first-issue latency, then free run.
    do_reset();
    chk("c0_en",    {31'b0, imem_en}, 32'd1);
    chk("c0_addr",  imem_addr, 32'h0);
    chk("c0_valid", {31'b0, ifid_valid}, 32'd0);
    chk("c0_pc",    ifid_pc, 32'h0);
    cyc(0, 0, 0);
    chk("c1_valid", {31'b0, ifid_valid}, 32'd0);
    chk("c1_addr",  imem_addr, 32'h4);
    cyc(0, 0, 0); chk_word("free_c2", 32'h0);
    cyc(0, 0, 0); chk_word("free_c3", 32'h4);
    cyc(0, 0, 0); chk_word("free_c4", 32'h8);

    // Stall for three cycles starting at cycle 3: in-flight 0x8 parks in the skid.
    do_reset();
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 1); chk_word("st_c3", 32'h4); chk("st_c3_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 1); chk_word("st_c4", 32'h4); chk("st_c4_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 1); chk_word("st_c5", 32'h4);
    cyc(0, 0, 0); chk_word("st_c6", 32'h4); chk("st_c6_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 0); chk_word("st_c7", 32'h8); chk("st_c7_addr", imem_addr, 32'hC);
    cyc(0, 0, 0); chk("st_c8_valid", {31'b0, ifid_valid}, 32'd0);
    cyc(0, 0, 0); chk_word("st_c9", 32'hC);
    cyc(0, 0, 0); chk_word("st_c10", 32'h10);

    // Redirect while the 0x8 response is pending.
    do_reset();
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 32'h100, 0); chk("rd_c3_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 0);
    chk("rd_c4_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rd_c4_addr", imem_addr, 32'h100);
    chk("rd_c4_en", {31'b0, imem_en}, 32'd1);
    cyc(0, 0, 0); chk("rd_c5_valid", {31'b0, ifid_valid}, 32'd0);
    cyc(0, 0, 0); chk_word("rd_c6", 32'h100);
    cyc(0, 0, 0); chk_word("rd_c7", 32'h104);

    // 8-bit PC wraps through zero.
    do_reset();
    redirect8 = 1'b1; redirect_pc8 = 8'hF8;
    cyc(0, 0, 0); redirect8 = 1'b0; #1;
    chk("w8_c1_addr", {24'b0, imem_addr8}, 32'hF8);
    chk("w8_c1_en", {31'b0, imem_en8}, 32'd1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("w8_c3_pc", {24'b0, ifid_pc8}, 32'hF8);
    chk("w8_c3_instr", {24'b0, ifid_instr8}, 32'h5D);
    cyc(0, 0, 0);
    chk("w8_c4_pc", {24'b0, ifid_pc8}, 32'hFC);
    chk("w8_c4_inc", {24'b0, ifid_pc_inc8}, 32'h00);
    cyc(0, 0, 0);
    chk("w8_c5_pc", {24'b0, ifid_pc8}, 32'h00);
    chk("w8_c5_inc", {24'b0, ifid_pc_inc8}, 32'h04);
    chk("w8_c5_valid", {31'b0, ifid_valid8}, 32'd1);

    // Redirect and stall together with the skid full: flush wins.
    do_reset();
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 32'h200, 1); chk("fl_c4_en", {31'b0, imem_en}, 32'd0);
    cyc(0, 0, 0);
    chk("fl_c5_valid", {31'b0, ifid_valid}, 32'd0);
    chk("fl_c5_en", {31'b0, imem_en}, 32'd1);
    chk("fl_c5_addr", imem_addr, 32'h200);
    cyc(0, 0, 0); chk("fl_c6_valid", {31'b0, ifid_valid}, 32'd0);
    cyc(0, 0, 0); chk_word("fl_c7", 32'h200);
    cyc(0, 0, 1); chk_word("fl_c8", 32'h204);
    cyc(0, 0, 1); chk_word("fl_c9", 32'h204);
    // Asynchronous reset mid-cycle while stalled.
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, ifid_valid}, 32'd0);
    chk("ar_instr", ifid_instr, 32'h0);
    chk("ar_pc", ifid_pc, 32'h0);
    chk("ar_inc", ifid_pc_inc, 32'h0);
    chk("ar_pcout", pc_out, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);

    // Randomized run: consumed words must follow program order from the last redirect.
    do_reset();
    exp_pc = 32'h0; consumed = 0; prev_hold = 1'b0; prev_pc = '0; prev_instr = '0;
    for (int i = 0; i < 500; i++) begin
      rd  = ($urandom_range(15) == 0);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      st  = ($urandom_range(2) == 0);
      cyc(rd, rpc, st);
      chk("rnd_addr", imem_addr, pc_out);
      if (prev_hold) begin
        chk("rnd_hold_pc", ifid_pc, prev_pc);
        chk("rnd_hold_instr", ifid_instr, prev_instr);
      end
      prev_hold  = ifid_valid && st && !rd;
      prev_pc    = ifid_pc;
      prev_instr = ifid_instr;
      if (rd) begin
        exp_pc = rpc;
      end else if (ifid_valid && !st) begin
        chk("rnd_pc", ifid_pc, exp_pc);
        chk("rnd_instr", ifid_instr, exp_pc ^ 32'hA5A5A5A5);
        chk("rnd_inc", ifid_pc_inc, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    chk("rnd_progress", {31'b0, (consumed > 100)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
